debounce_sync: RTL and testbench

- Upstream conditioning stage for the single-bit D flip-flop data path.
- Takes a raw asynchronous level input (switch or external pin) and passes it through a 2-stage synchronizer.
- Rejects pulses shorter than a programmable number of clocks.
- Outputs a clean registered level plus one-cycle rise/fall strobes, suitable for driving `d` of the downstream flip-flop stage.

---
 rtl/debounce_sync.sv | 123 ++++++++++++
 tb/tb_debounce_sync.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/debounce_sync.sv
// Purpose: 2-stage synchronizer plus glitch filter for a raw async level; emits clean q and rise/fall strobes.
// Latency: q/rise/fall update STABLE_CYCLES+1 edges after din is captured by the first sync flop.
// Backpressure: none; a free-running conditioning stage with no handshake.
module debounce_sync #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [1:0] STABLE_LOW  = 2'd0;
    localparam logic [1:0] CHECK_HIGH  = 2'd1;
    localparam logic [1:0] STABLE_HIGH = 2'd2;
    localparam logic [1:0] CHECK_LOW   = 2'd3;

    // Counter value on which a candidate level has been seen STABLE_CYCLES times.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    logic             sync_ff1;
    logic             sync_ff2;
    logic             s;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;

    // The FSM only ever looks at the synchronized copy.
    assign s = sync_ff2;

    // Two-flop synchronizer for the asynchronous input.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_ff1 <= 1'b0;
            sync_ff2 <= 1'b0;
        end else begin
            sync_ff1 <= din;
            sync_ff2 <= sync_ff1;
        end
    end

    // Qualification FSM: a new level must persist before q follows; strobes mark the edge of q.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= STABLE_LOW;
            cnt   <= CNT_ZERO;
            q     <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                STABLE_LOW: begin
                    if (s) begin
                        state <= CHECK_HIGH;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end else begin
                        cnt   <= CNT_ZERO;
                        busy  <= 1'b0;
                    end
                end
                CHECK_HIGH: begin
                    if (!s) begin
                        // Glitch: drop the attempt silently.
                        state <= STABLE_LOW;
                        cnt   <= CNT_ZERO;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        q     <= 1'b1;
                        rise  <= 1'b1;
                        state <= STABLE_HIGH;
                        cnt   <= CNT_ZERO;
                        busy  <= 1'b0;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        busy  <= 1'b1;
                    end
                end
                STABLE_HIGH: begin
                    if (!s) begin
                        state <= CHECK_LOW;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end else begin
                        cnt   <= CNT_ZERO;
                        busy  <= 1'b0;
                    end
                end
                CHECK_LOW: begin
                    if (s) begin
                        // Glitch: drop the attempt silently.
                        state <= STABLE_HIGH;
                        cnt   <= CNT_ZERO;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        q     <= 1'b0;
                        fall  <= 1'b1;
                        state <= STABLE_LOW;
                        cnt   <= CNT_ZERO;
                        busy  <= 1'b0;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    state <= STABLE_LOW;
                    cnt   <= CNT_ZERO;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debounce_sync.sv
// Purpose: directed plus random stimulus for debounce_sync against a window-based reference model.
// Latency: model predicts outputs per clock edge; outputs sampled 1 ns after each rising edge.
// Backpressure: not applicable.
`timescale 1ns/1ps
module tb_debounce_sync;

    localparam int SC    = 4;
    localparam int CNT_W = 8;

    logic clk;
    logic reset;
    logic din;
    logic q;
    logic rise;
    logic fall;
    logic busy;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: two-deep delay line and the window of recent synchronized samples.
    logic m1, m2;
    logic hist[$];
    logic q_m, rise_m, fall_m, busy_m;

    debounce_sync #(.STABLE_CYCLES(SC), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .q     (q),
        .rise  (rise),
        .fall  (fall),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge: drive inputs, advance the model, then compare all outputs.
    task automatic step(input logic d, input logic r);
        logic f;
        logic all_diff;
        din   = d;
        reset = r;
        @(posedge clk);
        if (!r) begin
            m1 = 1'b0;
            m2 = 1'b0;
            hist.delete();
            q_m    = 1'b0;
            rise_m = 1'b0;
            fall_m = 1'b0;
            busy_m = 1'b0;
        end else begin
            f  = m2;
            m2 = m1;
            m1 = d;
            hist.push_back(f);
            if (hist.size() > SC) void'(hist.pop_front());
            rise_m = 1'b0;
            fall_m = 1'b0;
            // q follows once SC consecutive synchronized samples all disagree with it.
            all_diff = (hist.size() == SC);
            foreach (hist[i]) if (hist[i] == q_m) all_diff = 1'b0;
            if (all_diff) begin
                q_m    = ~q_m;
                rise_m = q_m;
                fall_m = ~q_m;
            end
            busy_m = (f != q_m);
        end
        #1;
        chk("q", q, q_m);
        chk("rise", rise, rise_m);
        chk("fall", fall, fall_m);
        chk("busy", busy, busy_m);
        chk("rise_fall_excl", rise & fall, 1'b0);
        n_cmp++;
        assert (int'(dut.cnt) <= SC - 1) else begin
            n_err++;
            $error("FAIL cnt_bound observed=%0d expected<=%0d", dut.cnt, SC - 1);
        end
    endtask

    int rise_at;
    int n_rise;
    int n_fall;
    int busy_first;

    initial begin
        din   = 1'b1;
        reset = 1'b0;
        m1 = 0; m2 = 0; q_m = 0; rise_m = 0; fall_m = 0; busy_m = 0;

        // Reset held with din high: all outputs low.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        chk_int("reset_cnt", int'(dut.cnt), 0);

        // Clean rise: rise on the 6th step counting the capture edge as step 1.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
        rise_at = 0; busy_first = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b1);
            if (rise && rise_at == 0) rise_at = i;
            if (busy && busy_first == 0) busy_first = i;
        end
        chk_int("clean_rise_latency", rise_at, 6);
        chk_int("clean_rise_busy_start", busy_first, 3);
        chk("clean_rise_q", q, 1'b1);
        chk("clean_rise_busy_after", busy, 1'b0);

        // Glitch low for two clocks while q is high.
        n_fall = 0; busy_first = 0;
        step(1'b0, 1'b1); step(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1);
            if (fall) n_fall++;
            if (busy) busy_first = 1;
        end
        chk_int("glitch_fall_count", n_fall, 0);
        chk_int("glitch_busy_seen", busy_first, 1);
        chk("glitch_q", q, 1'b1);

        // Clean fall.
        rise_at = 0; n_rise = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1);
            if (fall && rise_at == 0) rise_at = i;
            if (rise) n_rise++;
        end
        chk_int("clean_fall_latency", rise_at, 6);
        chk_int("clean_fall_no_rise", n_rise, 0);
        chk("clean_fall_q", q, 1'b0);

        // Mid-qualification reset: capture edge, then three more edges gives cnt==2.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
        chk_int("midq_cnt_before", int'(dut.cnt), 2);
        step(1'b1, 1'b0);
        chk_int("midq_cnt_after", int'(dut.cnt), 0);
        rise_at = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b1);
            if (rise && rise_at == 0) rise_at = i;
        end
        chk_int("midq_release_latency", rise_at, 6);

        // Boundary: three synchronized high cycles rejected, four accepted.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
        n_rise = 0;
        for (int i = 0; i < 3; i++) begin step(1'b1, 1'b1); if (rise) n_rise++; end
        for (int i = 0; i < 8; i++) begin step(1'b0, 1'b1); if (rise) n_rise++; end
        chk_int("boundary3_rise", n_rise, 0);
        n_rise = 0;
        for (int i = 0; i < 4; i++) begin step(1'b1, 1'b1); if (rise) n_rise++; end
        for (int i = 0; i < 4; i++) begin step(1'b0, 1'b1); if (rise) n_rise++; end
        chk_int("boundary4_rise", n_rise, 1);

        // Random runs of varying length with occasional resets.
        for (int k = 0; k < 150; k++) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 7);
            for (int j = 0; j < len; j++) step(lvl, ($urandom_range(0, 59) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
